// File: rtl/frame_rate_divider.sv
// Frame/drop strobe generator: period shrinks with level down to MIN_PERIOD; enable_drop every frames_per_drop frames.
// Latency: strobes are registered and appear on the edge where the counter wraps. No backpressure: enable low freezes both counters.
// Optional FRD_LEVEL_IMMEDIATE_EN: a speed-up truncates the frame in progress instead of waiting for the next reload.
module frame_rate_divider #(
    parameter int CNT_W       = 23,
    parameter int BASE_PERIOD = 3333334,
    parameter int LEVEL_W     = 3,
    parameter int LEVEL_STEP  = 416667,
    parameter int MIN_PERIOD  = 833333,
    parameter int FRAME_W     = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               restart,
    input  logic [LEVEL_W-1:0] level,
    input  logic [FRAME_W-1:0] frames_per_drop,
    output logic               enable_frame,
    output logic               enable_drop,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int PROD_W = CNT_W + LEVEL_W;
    localparam logic [PROD_W-1:0] STEP        = PROD_W'(LEVEL_STEP);
    localparam logic [PROD_W-1:0] SPAN        = PROD_W'(BASE_PERIOD - MIN_PERIOD);
    localparam logic [PROD_W-1:0] BASE        = PROD_W'(BASE_PERIOD);
    localparam logic [PROD_W-1:0] MINP        = PROD_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]  BASE_RELOAD = CNT_W'(BASE_PERIOD - 1);

    logic [CNT_W-1:0]   counter;
    logic [PROD_W-1:0]  prod;
    logic [PROD_W-1:0]  period;
    logic [CNT_W-1:0]   reload;
    logic [FRAME_W-1:0] fpd_last;
    logic               last_frame;

    // Comparing against the span avoids underflow of BASE - prod at high levels.
    always_comb begin
        prod       = PROD_W'(level) * STEP;
        period     = (prod >= SPAN) ? MINP : (BASE - prod);
        reload     = CNT_W'(period - PROD_W'(1));
        fpd_last   = (frames_per_drop == '0) ? '0 : (frames_per_drop - FRAME_W'(1));
        last_frame = (frame_count >= fpd_last);
    end

`ifdef FRD_LEVEL_IMMEDIATE_EN
    logic [LEVEL_W-1:0] level_q;

    // Sampled at reset too, so a non-zero level at reset does not truncate the first frame.
    always_ff @(posedge clk) begin
        if (!resetn || restart || enable) begin
            level_q <= level;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            counter      <= BASE_RELOAD;
            frame_count  <= '0;
            enable_frame <= 1'b0;
            enable_drop  <= 1'b0;
        end else if (restart) begin
            counter      <= reload;
            frame_count  <= '0;
            enable_frame <= 1'b0;
            enable_drop  <= 1'b0;
        end else if (enable) begin
            if (counter == '0) begin
                counter      <= reload;
                enable_frame <= 1'b1;
                if (last_frame) begin
                    enable_drop <= 1'b1;
                    frame_count <= '0;
                end else begin
                    enable_drop <= 1'b0;
                    frame_count <= frame_count + FRAME_W'(1);
                end
`ifdef FRD_LEVEL_IMMEDIATE_EN
            end else if ((level != level_q) && (counter > reload)) begin
                counter      <= reload;
                enable_frame <= 1'b0;
                enable_drop  <= 1'b0;
`endif
            end else begin
                counter      <= counter - CNT_W'(1);
                enable_frame <= 1'b0;
                enable_drop  <= 1'b0;
            end
        end else begin
            enable_frame <= 1'b0;
            enable_drop  <= 1'b0;
        end
    end

endmodule
